// File: rtl/fir_pipe_param.sv
// fir_pipe_param: parameterised, fully pipelined direct-form FIR with indexed coefficient writes.
// Optional macro FIR_CLR_EN adds a clr input that flushes sample history and the valid pipeline.
module fir_pipe_param #(
    parameter int unsigned TAPS   = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned AW     = $clog2(TAPS),
    parameter int unsigned OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x,
    input  logic              coef_wr,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
`ifdef FIR_CLR_EN
    input  logic              clr,
`endif
    output logic              out_valid,
    output logic [OUT_W-1:0]  y
);

    localparam int unsigned LVLS  = $clog2(TAPS);
    localparam int unsigned NP    = 1 << LVLS;
    localparam int unsigned NODES = 2 * NP - 1;
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned LAT   = 3 + LVLS;

    logic [DATA_W-1:0] taps  [TAPS];
    logic [COEF_W-1:0] coef  [TAPS];
    logic [OUT_W-1:0]  node  [NODES];
    logic [LAT-2:0]    vpipe;
    logic              hist_clr;

`ifdef FIR_CLR_EN
    assign hist_clr = clr;
`else
    assign hist_clr = 1'b0;
`endif

    // Full-precision product, sign- or zero-extended to the accumulator width.
    function automatic logic [OUT_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [COEF_W-1:0] b);
        logic signed [PW-1:0] sp;
        logic        [PW-1:0] up;
        sp = PW'($signed(a)) * PW'($signed(b));
        up = PW'(a) * PW'(b);
        if (SIGNED != 0) begin
            return OUT_W'(sp);
        end
        return OUT_W'(up);
    endfunction

    // Coefficient bank; out-of-range addresses match no tap and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                if (coef_addr == AW'(i)) begin
                    coef[i] <= coef_data;
                end
            end
        end
    end

    // Delay line: taps[0] is the newest sample; shifts only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                taps[i] <= '0;
            end
        end else begin
            if (hist_clr) begin
                for (int unsigned i = 0; i < TAPS; i++) begin
                    taps[i] <= '0;
                end
            end
            if (in_valid) begin
                taps[0] <= x;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    taps[i] <= hist_clr ? '0 : taps[i-1];
                end
            end
        end
    end

    // Heap-ordered tree: leaves NP-1.. hold products, node 0 is the root.
    // Padding leaves stay zero so every path has the same register depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < NODES; n++) begin
                node[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < NP - 1; n++) begin
                node[n] <= node[2*n+1] + node[2*n+2];
            end
            for (int unsigned i = 0; i < TAPS; i++) begin
                node[NP-1+i] <= mul_ext(taps[i], coef[i]);
            end
            for (int unsigned i = TAPS; i < NP; i++) begin
                node[NP-1+i] <= '0;
            end
        end
    end

    // Valid tracks the datapath depth; the arithmetic stages need no flush on clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe     <= '0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            y <= node[0];
            if (hist_clr) begin
                vpipe     <= (LAT-1)'(in_valid);
                out_valid <= 1'b0;
            end else begin
                vpipe     <= {vpipe[LAT-3:0], in_valid};
                out_valid <= vpipe[LAT-2];
            end
        end
    end

endmodule

// File: tb/tb_fir_pipe_param.sv
// Bench for fir_pipe_param: three instances (4-tap unsigned, 4-tap signed, 3-tap unsigned)
// share one stimulus stream and are compared every cycle against a sum-of-products model.
module tb_fir_pipe_param;

    localparam int LAT  = 5;
    localparam int NCYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic        coef_wr = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;

    logic        ov_u, ov_s, ov_3;
    logic [33:0] y_u, y_s, y_3;

    always #5 clk = ~clk;

    fir_pipe_param #(.TAPS(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_CLR_EN
        .clr(1'b0),
`endif
        .out_valid(ov_u), .y(y_u));

    fir_pipe_param #(.TAPS(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_CLR_EN
        .clr(1'b0),
`endif
        .out_valid(ov_s), .y(y_s));

    fir_pipe_param #(.TAPS(3), .SIGNED(0)) dut_3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_CLR_EN
        .clr(1'b0),
`endif
        .out_valid(ov_3), .y(y_3));

    // Model state: coefficient banks, sample history, per-cycle expectations.
    logic [15:0] b_u [4];
    logic [15:0] b_s [4];
    logic [15:0] b_3 [3];
    logic [15:0] hist [4];
    bit          acc  [NCYC];
    logic [33:0] ey_u [NCYC];
    logic [33:0] ey_s [NCYC];
    logic [33:0] ey_3 [NCYC];
    int          cyc = 0;
    int          last_rst = -1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: y[k] = sum b[i]*x[k-i], with writes in the sample's own cycle applied first.
    initial begin
        int     n, idx;
        longint su, ss, s3;
        forever begin
            @(posedge clk);
            n   = cyc;
            idx = n % NCYC;
            acc[idx] = 1'b0;
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    b_u[i] = '0; b_s[i] = '0; hist[i] = '0;
                end
                for (int i = 0; i < 3; i++) b_3[i] = '0;
                last_rst = n;
            end else begin
                if (coef_wr) begin
                    b_u[int'(coef_addr)] = coef_data;
                    b_s[int'(coef_addr)] = coef_data;
                    if (int'(coef_addr) < 3) b_3[int'(coef_addr)] = coef_data;
                end
                if (in_valid) begin
                    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = x;
                    su = 0; ss = 0; s3 = 0;
                    for (int i = 0; i < 4; i++) begin
                        su += longint'(b_u[i]) * longint'(hist[i]);
                        ss += longint'($signed(b_s[i])) * longint'($signed(hist[i]));
                    end
                    for (int i = 0; i < 3; i++) s3 += longint'(b_3[i]) * longint'(hist[i]);
                    ey_u[idx] = 34'(su);
                    ey_s[idx] = 34'(ss);
                    ey_3[idx] = 34'(s3);
                    acc[idx]  = 1'b1;
                end
            end
            cyc = n + 1;
        end
    end

    // Per-cycle compare: out_valid always, y only when valid; reset state after rst.
    initial begin
        int n, t;
        bit ev;
        forever begin
            @(negedge clk);
            n = cyc;
            if (last_rst >= 0) begin
                if (last_rst == n - 1) begin
                    chk("rst_ov_u", 34'(ov_u), 34'd0);
                    chk("rst_ov_s", 34'(ov_s), 34'd0);
                    chk("rst_ov_3", 34'(ov_3), 34'd0);
                    chk("rst_y_u", y_u, 34'd0);
                    chk("rst_y_s", y_s, 34'd0);
                    chk("rst_y_3", y_3, 34'd0);
                end else begin
                    t  = n - LAT;
                    ev = (t > last_rst) && acc[t % NCYC];
                    chk("ov_u", 34'(ov_u), 34'(ev));
                    chk("ov_s", 34'(ov_s), 34'(ev));
                    chk("ov_3", 34'(ov_3), 34'(ev));
                    if (ev) begin
                        chk("y_u", y_u, ey_u[t % NCYC]);
                        chk("y_s", y_s, ey_s[t % NCYC]);
                        chk("y_3", y_3, ey_3[t % NCYC]);
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic iv, input logic [15:0] xv,
                        input logic wr, input logic [1:0] a, input logic [15:0] d,
                        output int t);
        @(negedge clk);
        rst = r; in_valid = iv; x = xv; coef_wr = wr; coef_addr = a; coef_data = d;
        t = cyc;
    endtask

    task automatic idle(input int k);
        int t;
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 16'd0, t);
    endtask

    task automatic do_reset(input int k);
        int t;
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 16'd0, 1'b0, 2'd0, 16'd0, t);
    endtask

    task automatic wr4(input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] c2, input logic [15:0] c3);
        int t;
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd0, c0, t);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd1, c1, t);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd2, c2, t);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd3, c3, t);
    endtask

    initial begin
        int ts [5];
        int t;
        logic [15:0] xv;

        // Back-to-back ramp with b=1,2,3,4 (3-tap instance ignores address 3).
        do_reset(3);
        wr4(16'd1, 16'd2, 16'd3, 16'd4);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'(k + 1), 1'b0, 2'd0, 16'd0, ts[k]);
        idle(LAT + 3);
        chk("pin_ramp0", ey_u[ts[0] % NCYC], 34'd1);
        chk("pin_ramp1", ey_u[ts[1] % NCYC], 34'd4);
        chk("pin_ramp2", ey_u[ts[2] % NCYC], 34'd10);
        chk("pin_ramp3", ey_u[ts[3] % NCYC], 34'd20);
        chk("pin_ramp4", ey_u[ts[4] % NCYC], 34'd30);
        chk("pin_ramp3_t3", ey_3[ts[3] % NCYC], 34'd16);
        chk("pin_ramp4_t3", ey_3[ts[4] % NCYC], 34'd22);

        // Bubbles between samples must not disturb the history.
        do_reset(1);
        wr4(16'd1, 16'd2, 16'd3, 16'd4);
        step(1'b0, 1'b1, 16'd1, 1'b0, 2'd0, 16'd0, ts[0]);
        idle(1);
        step(1'b0, 1'b1, 16'd2, 1'b0, 2'd0, 16'd0, ts[1]);
        idle(2);
        step(1'b0, 1'b1, 16'd3, 1'b0, 2'd0, 16'd0, ts[2]);
        idle(LAT + 3);
        chk("pin_gap0", ey_u[ts[0] % NCYC], 34'd1);
        chk("pin_gap1", ey_u[ts[1] % NCYC], 34'd4);
        chk("pin_gap2", ey_u[ts[2] % NCYC], 34'd10);

        // All-ones extremes: widest unsigned sum, and -1*-1 per tap when signed.
        do_reset(1);
        wr4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'hFFFF, 1'b0, 2'd0, 16'd0, ts[k]);
        idle(LAT + 3);
        chk("pin_max3", ey_u[ts[3] % NCYC], 34'h3_FFF8_0004);
        chk("pin_max4", ey_u[ts[4] % NCYC], 34'h3_FFF8_0004);
        chk("pin_max3_s", ey_s[ts[3] % NCYC], 34'h0_0000_0004);

        // Most-negative sample times -1.
        do_reset(1);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd0, 16'hFFFF, t);
        step(1'b0, 1'b1, 16'h8000, 1'b0, 2'd0, 16'd0, ts[0]);
        idle(LAT + 3);
        chk("pin_neg_s", ey_s[ts[0] % NCYC], 34'h0_0000_8000);
        chk("pin_neg_u", ey_u[ts[0] % NCYC], 34'h0_7FFF_8000);

        // Coefficient timing: same-cycle write applies, a later write does not.
        do_reset(1);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd0, 16'd1, t);
        step(1'b0, 1'b1, 16'd9, 1'b1, 2'd0, 16'd2, ts[0]);
        step(1'b0, 1'b1, 16'd9, 1'b0, 2'd0, 16'd0, ts[1]);
        step(1'b0, 1'b0, 16'd0, 1'b1, 2'd0, 16'd3, t);
        step(1'b0, 1'b1, 16'd9, 1'b0, 2'd0, 16'd0, ts[2]);
        idle(LAT + 3);
        chk("pin_cw0", ey_u[ts[0] % NCYC], 34'd18);
        chk("pin_cw1", ey_u[ts[1] % NCYC], 34'd18);
        chk("pin_cw2", ey_u[ts[2] % NCYC], 34'd27);

        // Reset mid-stream discards in-flight samples.
        do_reset(1);
        wr4(16'd1, 16'd2, 16'd3, 16'd4);
        step(1'b0, 1'b1, 16'd5, 1'b0, 2'd0, 16'd0, t);
        step(1'b0, 1'b1, 16'd6, 1'b0, 2'd0, 16'd0, t);
        step(1'b1, 1'b1, 16'd8, 1'b0, 2'd0, 16'd0, t);
        wr4(16'd1, 16'd1, 16'd1, 16'd1);
        step(1'b0, 1'b1, 16'd7, 1'b0, 2'd0, 16'd0, ts[0]);
        idle(LAT + 3);
        chk("pin_midrst", ey_u[ts[0] % NCYC], 34'd7);

        // Random traffic: samples, bubbles, coefficient writes, rare resets.
        do_reset(1);
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 7))
                0:       xv = 16'hFFFF;
                1:       xv = 16'h8000;
                default: xv = 16'($urandom);
            endcase
            step(1'b0 == 1'b1 || $urandom_range(0, 249) == 0,
                 $urandom_range(0, 3) != 0, xv,
                 $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                 16'($urandom), t);
        end
        idle(LAT + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
